mire_writer: RTL

Wishbone master that fills the SDRAM frame buffer with an animated grid test pattern, using the same address layout the display controller reads: one 32-bit word per pixel, `adr = 4*(y*HDISP + x)`, data `{8'h00, R, G, B}`. It sits upstream of the display read path on the shared Wishbone interconnect. It periodically releases `cyc` so the arbiter can serve the display reader.

---
 rtl/video_pkg.sv | 17 +
 rtl/wshb_if.sv | 28 ++
 rtl/mire_writer_pixel_scanner.sv | 67 ++++++
 rtl/mire_writer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types and writer FSM encoding for the frame-buffer pattern writer.
package video_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t WHITE = 24'hFF_FFFF;
    localparam rgb_t BLACK = 24'h00_0000;

    localparam int unsigned BURST_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PAUSE
    } wr_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the pattern writer and the display reader.
interface wshb_if (
    input logic clk,
    input logic rst
);

    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, ack, dat_sm,
        output adr, dat_ms, cyc, stb, we, sel, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, cyc, stb, we, sel, cti, bte,
        output ack, dat_sm
    );

endinterface

// File: rtl/mire_writer_pixel_scanner.sv
// Raster position tracker: x/y counters and a linearly incrementing byte address.
module pixel_scanner
    import video_pkg::*;
#(
    parameter  int unsigned HDISP = 800,
    parameter  int unsigned VDISP = 480,
    localparam int unsigned XW    = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_nxt_o,
    output logic [YW-1:0] y_nxt_o,
    output logic [31:0]   adr_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   adr_q, adr_d;
    logic          at_eol;
    logic          at_last;

    assign at_eol  = (x_q == XW'(HDISP - 1));
    assign at_last = at_eol && (y_q == YW'(VDISP - 1));

    // Address steps by one word per pixel so no y*HDISP multiply is needed.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        adr_d = adr_q;
        if (advance_i) begin
            if (at_last) begin
                x_d   = '0;
                y_d   = '0;
                adr_d = '0;
            end else begin
                adr_d = adr_q + 32'd4;
                if (at_eol) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q   <= '0;
            y_q   <= '0;
            adr_q <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            adr_q <= adr_d;
        end
    end

    assign x_nxt_o = x_d;
    assign y_nxt_o = y_d;
    assign adr_o   = adr_q;
    assign last_o  = at_last;

endmodule

// File: rtl/mire_writer.sv
// Wishbone master that paints a scrolling grid into the frame buffer, releasing
// the bus after every burst so the display reader can be served.
module mire_writer
    import video_pkg::*;
#(
    parameter  int unsigned HDISP = 800,
    parameter  int unsigned VDISP = 480,
    parameter  int unsigned BURST = BURST_DEFAULT,
    localparam int unsigned XW    = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int unsigned YW    = (VDISP > 1) ? $clog2(VDISP) : 1,
    localparam int unsigned BW    = (BURST > 1) ? $clog2(BURST) : 1
) (
    wshb_if.master wshb_ifm,
    input  logic   enable,
    output logic   frame_done
);

    wr_state_t     state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          fd_q, fd_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [7:0]    fc_q, fc_d;
    rgb_t          pix_q, pix_d;

    logic          accept;
    logic          burst_end;
    logic          last;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic [31:0]   adr;
    logic          unused_dat_sm;

    function automatic rgb_t pattern(input logic [XW-1:0] x,
                                     input logic [YW-1:0] y,
                                     input logic [7:0]    fc);
        logic [XW:0] sum;
        logic [31:0] sw;
        logic [31:0] yw;
        sum = {1'b0, x} + (XW + 1)'(fc[3:0]);
        sw  = 32'(sum);
        yw  = 32'(y);
        return ((sw[3:0] == 4'd0) || (yw[3:0] == 4'd0)) ? WHITE : BLACK;
    endfunction

    pixel_scanner #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_scan (
        .clk_i     (wshb_ifm.clk),
        .rst_i     (wshb_ifm.rst),
        .advance_i (accept),
        .x_nxt_o   (x_nxt),
        .y_nxt_o   (y_nxt),
        .adr_o     (adr),
        .last_o    (last)
    );

    assign accept    = cyc_q & wshb_ifm.ack;
    assign burst_end = (burst_q == BW'(BURST - 1));

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        fc_d    = fc_q;
        fd_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = WRITE;
            end
            WRITE: begin
                // A falling enable only takes effect once the pending write is acked.
                if (accept) begin
                    burst_d = burst_end ? '0 : burst_q + 1'b1;
                    if (last) begin
                        fc_d = fc_q + 8'd1;
                        fd_d = 1'b1;
                    end
                    if (burst_end || last || !enable) state_d = PAUSE;
                end
            end
            PAUSE: begin
                burst_d = '0;
                state_d = enable ? WRITE : IDLE;
            end
            default: state_d = IDLE;
        endcase
        cyc_d = (state_d == WRITE);
        pix_d = pattern(x_nxt, y_nxt, fc_d);
    end

    always_ff @(posedge wshb_ifm.clk) begin
        if (wshb_ifm.rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            fd_q    <= 1'b0;
            burst_q <= '0;
            fc_q    <= '0;
            pix_q   <= WHITE;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            fd_q    <= fd_d;
            burst_q <= burst_d;
            fc_q    <= fc_d;
            pix_q   <= pix_d;
        end
    end

    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.dat_ms = {8'h00, pix_q};
    assign wshb_ifm.cyc    = cyc_q;
    assign wshb_ifm.stb    = cyc_q;
    assign wshb_ifm.we     = 1'b1;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;
    assign frame_done      = fd_q;
    assign unused_dat_sm   = ^wshb_ifm.dat_sm;

endmodule
